bit_error_counter: RTL and testbench

//   Compares the received bit stream against the delay-aligned reference (PRBS) bit from the

---
 rtl/bit_error_counter.sv | 136 +++++++++++++
 tb/tb_bit_error_counter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/bit_error_counter.sv
// Bit error counter: compares the received bit stream against the aligned
// reference bit. It counts compared bits and bit errors over a measurement
// window that is set when a measurement starts.
module bit_error_counter #(
    parameter int WIN_WIDTH = 16,
    parameter int ERR_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 ref_bit,
    input  logic                 rx_bit,
    input  logic                 start,
    input  logic                 clear,
    input  logic [WIN_WIDTH-1:0] window_len,
    output logic                 busy,
    output logic                 done,
    output logic                 error_flag,
    output logic [ERR_WIDTH-1:0] error_count,
    output logic [WIN_WIDTH-1:0] bit_count,
    output logic                 err_sat
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MEASURE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    localparam logic [ERR_WIDTH-1:0] ERR_MAX = {ERR_WIDTH{1'b1}};
    localparam logic [ERR_WIDTH-1:0] ERR_ONE = {{(ERR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIN_WIDTH-1:0] WIN_ONE = {{(WIN_WIDTH-1){1'b0}}, 1'b1};

    state_t                state_q, state_d;
    logic [WIN_WIDTH-1:0]  win_q, win_d;
    logic [WIN_WIDTH-1:0]  bit_cnt_q, bit_cnt_d;
    logic [ERR_WIDTH-1:0]  err_cnt_q, err_cnt_d;
    logic                  err_flag_q, err_flag_d;
    logic                  err_sat_q, err_sat_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  mismatch;
    logic [ERR_WIDTH-1:0]  err_inc;
    logic [WIN_WIDTH-1:0]  bit_inc;

    assign mismatch = ref_bit ^ rx_bit;
    assign err_inc  = err_cnt_q + ERR_ONE;
    assign bit_inc  = bit_cnt_q + WIN_ONE;

    // Next-state logic: clear has priority over everything, and start (re)arms from IDLE or DONE
    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        bit_cnt_d  = bit_cnt_q;
        err_cnt_d  = err_cnt_q;
        err_flag_d = err_flag_q;
        err_sat_d  = err_sat_q;

        if (clear) begin
            state_d    = S_IDLE;
            bit_cnt_d  = '0;
            err_cnt_d  = '0;
            err_flag_d = 1'b0;
            err_sat_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    // The error flag is only meaningful while measuring.
                    err_flag_d = 1'b0;
                    if (start) begin
                        win_d     = window_len;
                        bit_cnt_d = '0;
                        err_cnt_d = '0;
                        err_sat_d = 1'b0;
                        // A zero-length window completes immediately with empty counts.
                        state_d   = (window_len == '0) ? S_DONE : S_MEASURE;
                    end
                end
                S_MEASURE: begin
                    if (enable) begin
                        bit_cnt_d  = bit_inc;
                        err_flag_d = mismatch;
                        if (mismatch && (err_cnt_q != ERR_MAX)) begin
                            err_cnt_d = err_inc;
                            if (err_inc == ERR_MAX) begin
                                err_sat_d = 1'b1;
                            end
                        end
                        // The bit that fills the window is counted on the same edge that ends it.
                        if (bit_inc == win_q) begin
                            state_d    = S_DONE;
                            err_flag_d = 1'b0;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d == S_MEASURE);
        done_d = (state_d == S_DONE);
    end

    // State and output registers, cleared asynchronously by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            win_q      <= '0;
            bit_cnt_q  <= '0;
            err_cnt_q  <= '0;
            err_flag_q <= 1'b0;
            err_sat_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            bit_cnt_q  <= bit_cnt_d;
            err_cnt_q  <= err_cnt_d;
            err_flag_q <= err_flag_d;
            err_sat_q  <= err_sat_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign error_flag  = err_flag_q;
    assign error_count = err_cnt_q;
    assign bit_count   = bit_cnt_q;
    assign err_sat     = err_sat_q;

endmodule

// File: tb/tb_bit_error_counter.sv
// Directed testbench for bit_error_counter: a 16/16 instance plus a 4-bit
// error counter instance that shares the same stimulus.
module tb_bit_error_counter;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        ref_bit;
    logic        rx_bit;
    logic        start;
    logic        clear;
    logic [15:0] window_len;

    logic        busy, done, error_flag, err_sat;
    logic [15:0] error_count;
    logic [15:0] bit_count;

    logic        busy4, done4, error_flag4, err_sat4;
    logic [3:0]  error_count4;
    logic [15:0] bit_count4;

    int checks = 0;
    int errors = 0;

    bit_error_counter #(.WIN_WIDTH(16), .ERR_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .enable(enable), .ref_bit(ref_bit), .rx_bit(rx_bit),
        .start(start), .clear(clear), .window_len(window_len),
        .busy(busy), .done(done), .error_flag(error_flag),
        .error_count(error_count), .bit_count(bit_count), .err_sat(err_sat)
    );

    bit_error_counter #(.WIN_WIDTH(16), .ERR_WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .enable(enable), .ref_bit(ref_bit), .rx_bit(rx_bit),
        .start(start), .clear(clear), .window_len(window_len),
        .busy(busy4), .done(done4), .error_flag(error_flag4),
        .error_count(error_count4), .bit_count(bit_count4), .err_sat(err_sat4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int len);
        window_len = 16'(len);
        start      = 1'b1;
        step();
        start      = 1'b0;
    endtask

    initial begin
        int exp_ec;
        int exp_bc;
        bit flip;

        reset = 1'b1; enable = 1'b0; ref_bit = 1'b0; rx_bit = 1'b0;
        start = 1'b0; clear = 1'b0; window_len = 16'd0;
        step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_flag", 32'(error_flag), 32'd0);
        check("rst_ec", 32'(error_count), 32'd0);
        check("rst_bc", 32'(bit_count), 32'd0);
        check("rst_sat", 32'(err_sat), 32'd0);
        reset = 1'b0;
        step();
        $display("reset: busy=%0d done=%0d ec=%0d bc=%0d", busy, done, error_count, bit_count);

        // 1: clean 100-bit window
        enable = 1'b1;
        do_start(100);
        check("t1_busy_after_start", 32'(busy), 32'd1);
        check("t1_bc_after_start", 32'(bit_count), 32'd0);
        for (int i = 0; i < 100; i++) begin
            ref_bit = 1'($urandom_range(0, 1));
            rx_bit  = ref_bit;
            step();
            if (i < 99) begin
                check("t1_busy_mid", 32'(busy), 32'd1);
                check("t1_done_mid", 32'(done), 32'd0);
            end
        end
        check("t1_done", 32'(done), 32'd1);
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_bc", 32'(bit_count), 32'd100);
        check("t1_ec", 32'(error_count), 32'd0);
        check("t1_sat", 32'(err_sat), 32'd0);
        $display("t1 clean window: done=%0d bc=%0d ec=%0d", done, bit_count, error_count);

        // 2: errors at bits 10, 11, 57; restart from DONE
        do_start(100);
        check("t2_busy_after_start", 32'(busy), 32'd1);
        check("t2_done_after_start", 32'(done), 32'd0);
        check("t2_bc_zeroed", 32'(bit_count), 32'd0);
        exp_ec = 0;
        for (int i = 0; i < 100; i++) begin
            flip    = (i == 10) || (i == 11) || (i == 57);
            ref_bit = 1'($urandom_range(0, 1));
            rx_bit  = ref_bit ^ flip;
            step();
            if (flip) exp_ec++;
            check("t2_ec_running", 32'(error_count), 32'(exp_ec));
            if (i < 99) check("t2_flag", 32'(error_flag), 32'(flip));
        end
        check("t2_ec", 32'(error_count), 32'd3);
        check("t2_bc", 32'(bit_count), 32'd100);
        check("t2_done", 32'(done), 32'd1);
        check("t2_flag_done", 32'(error_flag), 32'd0);
        $display("t2 three errors: ec=%0d bc=%0d done=%0d", error_count, bit_count, done);

        // 3: enable toggling, half the clocks compare
        do_start(100);
        exp_bc = 0;
        for (int k = 0; k < 200; k++) begin
            enable  = ((k % 2) == 0);
            ref_bit = 1'($urandom_range(0, 1));
            rx_bit  = ref_bit;
            step();
            if (enable && exp_bc < 100) exp_bc++;
            check("t3_bc", 32'(bit_count), 32'(exp_bc));
            check("t3_done", 32'(done), 32'(exp_bc == 100));
        end
        check("t3_ec", 32'(error_count), 32'd0);
        enable = 1'b1;
        $display("t3 gated enable: bc=%0d done=%0d", bit_count, done);

        // 4: every bit wrong, 4-bit counter saturates
        do_start(20);
        for (int i = 0; i < 20; i++) begin
            ref_bit = 1'($urandom_range(0, 1));
            rx_bit  = ~ref_bit;
            step();
        end
        check("t4_ec4", 32'(error_count4), 32'd15);
        check("t4_sat4", 32'(err_sat4), 32'd1);
        check("t4_bc4", 32'(bit_count4), 32'd20);
        check("t4_done4", 32'(done4), 32'd1);
        check("t4_ec16", 32'(error_count), 32'd20);
        check("t4_sat16", 32'(err_sat), 32'd0);
        $display("t4 saturation: ec4=%0d sat4=%0d ec16=%0d", error_count4, err_sat4, error_count);

        // 5: clear mid-window, start+clear, reset mid-window
        do_start(100);
        for (int i = 0; i < 40; i++) begin
            ref_bit = 1'($urandom_range(0, 1));
            rx_bit  = (i < 5) ? ~ref_bit : ref_bit;
            step();
        end
        check("t5_bc40", 32'(bit_count), 32'd40);
        check("t5_ec5", 32'(error_count), 32'd5);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("t5_clr_busy", 32'(busy), 32'd0);
        check("t5_clr_done", 32'(done), 32'd0);
        check("t5_clr_bc", 32'(bit_count), 32'd0);
        check("t5_clr_ec", 32'(error_count), 32'd0);
        clear = 1'b1; start = 1'b1; window_len = 16'd100;
        step();
        clear = 1'b0; start = 1'b0;
        check("t5_sc_busy", 32'(busy), 32'd0);
        check("t5_sc_done", 32'(done), 32'd0);
        do_start(100);
        for (int i = 0; i < 30; i++) begin
            ref_bit = 1'($urandom_range(0, 1));
            rx_bit  = ~ref_bit;
            step();
        end
        check("t5_ec30", 32'(error_count), 32'd30);
        check("t5_flag_pre_rst", 32'(error_flag), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_ec", 32'(error_count), 32'd0);
        check("t5_rst_bc", 32'(bit_count), 32'd0);
        check("t5_rst_flag", 32'(error_flag), 32'd0);
        step();
        reset = 1'b0;
        step();
        check("t5_after_rst_done", 32'(done), 32'd0);
        $display("t5 clear/reset: busy=%0d ec=%0d bc=%0d", busy, error_count, bit_count);

        // 6: zero-length window and restart from DONE
        do_start(5);
        for (int i = 0; i < 5; i++) begin
            ref_bit = 1'($urandom_range(0, 1));
            rx_bit  = ~ref_bit;
            step();
        end
        check("t6_ec5", 32'(error_count), 32'd5);
        check("t6_done5", 32'(done), 32'd1);
        do_start(0);
        check("t6_zero_done", 32'(done), 32'd1);
        check("t6_zero_busy", 32'(busy), 32'd0);
        check("t6_zero_bc", 32'(bit_count), 32'd0);
        check("t6_zero_ec", 32'(error_count), 32'd0);
        do_start(3);
        check("t6_rs_busy", 32'(busy), 32'd1);
        check("t6_rs_bc", 32'(bit_count), 32'd0);
        window_len = 16'd1;
        ref_bit = 1'b1; rx_bit = 1'b1;
        step();
        check("t6_winchg_busy", 32'(busy), 32'd1);
        step();
        step();
        check("t6_rs_done", 32'(done), 32'd1);
        check("t6_rs_bc3", 32'(bit_count), 32'd3);
        $display("t6 zero window/restart: done=%0d bc=%0d", done, bit_count);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
